// File: rtl/multi_ch_clk_div.sv
// Multi-channel programmable integer clock divider. Ratios change only at period
// boundaries; channels start and stop glitch-free, and a global align restarts them in phase.
module multi_ch_clk_div #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DIV_W-1:0] cfg_div,
  input  logic [NUM_CH-1:0]       cfg_req,
  output logic [NUM_CH-1:0]       cfg_ack,
  input  logic                    align,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_flag_q, pend_flag_d;
    logic [DIV_W-1:0] raw_div, req_div;
    logic [DIV_W:0]   high_cnt;
    logic             active, boundary, ack_d;
    logic             clk_q, tick_q, ack_q, busy_q;

    assign raw_div  = cfg_div[gi*DIV_W +: DIV_W];
    assign req_div  = (raw_div < MIN_DIV) ? MIN_DIV : raw_div;
    assign active   = (state_q != IDLE);
    assign boundary = active && (cnt_q == cur_div_q - ONE);

    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cur_div_d   = cur_div_q;
      pend_div_d  = pend_div_q;
      pend_flag_d = pend_flag_q;
      ack_d       = 1'b0;
      if (!active) begin
        // An idle channel has no period to protect, so a new ratio lands immediately.
        cnt_d = '0;
        if (cfg_req[gi]) begin
          cur_div_d   = req_div;
          pend_flag_d = 1'b0;
          ack_d       = 1'b1;
        end else if (pend_flag_q) begin
          cur_div_d   = pend_div_q;
          pend_flag_d = 1'b0;
          ack_d       = 1'b1;
        end
        if (ch_en[gi]) state_d = RUN;
      end else begin
        state_d = ch_en[gi] ? RUN : STOP;
        if (align || boundary) begin
          cnt_d = '0;
          if (pend_flag_q) begin
            cur_div_d   = pend_div_q;
            pend_flag_d = 1'b0;
            ack_d       = 1'b1;
          end
          if (boundary && !align && !ch_en[gi]) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
        // A request arriving with an apply is held for the following boundary.
        if (cfg_req[gi]) begin
          pend_div_d  = req_div;
          pend_flag_d = 1'b1;
        end
      end
    end

    assign high_cnt = ({1'b0, cur_div_d} + (DIV_W+1)'(1)) >> 1;

    always_ff @(posedge clk_in) begin
      if (rst) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        cur_div_q   <= DEF_DIV;
        pend_div_q  <= DEF_DIV;
        pend_flag_q <= 1'b0;
        clk_q       <= 1'b0;
        tick_q      <= 1'b0;
        ack_q       <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        cur_div_q   <= cur_div_d;
        pend_div_q  <= pend_div_d;
        pend_flag_q <= pend_flag_d;
        clk_q       <= (state_d != IDLE) && ({1'b0, cnt_d} < high_cnt);
        tick_q      <= (state_d != IDLE) && (cnt_d == cur_div_d - ONE);
        ack_q       <= ack_d;
        busy_q      <= pend_flag_d;
      end
    end

    assign clk_out[gi] = clk_q;
    assign tick[gi]    = tick_q;
    assign cfg_ack[gi] = ack_q;
    assign busy[gi]    = busy_q;
  end

endmodule

// File: tb/tb_multi_ch_clk_div.sv
// Self-checking bench for multi_ch_clk_div: directed scenarios plus random traffic,
// all compared against a time-based period model of each channel.
module tb_multi_ch_clk_div;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int DEF    = 2;

  logic                    clk_in = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       ch_en, cfg_req, cfg_ack, clk_out, tick, busy;
  logic [NUM_CH*DIV_W-1:0] cfg_div;
  logic                    align;

  always #5 clk_in = ~clk_in;

  multi_ch_clk_div #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF)) dut (
    .clk_in(clk_in), .rst(rst), .ch_en(ch_en), .cfg_div(cfg_div), .cfg_req(cfg_req),
    .cfg_ack(cfg_ack), .align(align), .clk_out(clk_out), .tick(tick), .busy(busy)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: each running channel is a period of length m_n that began at cycle m_start.
  bit m_act[NUM_CH];
  int m_start[NUM_CH];
  int m_n[NUM_CH];
  bit m_pv[NUM_CH];
  int m_pd[NUM_CH];
  logic [NUM_CH-1:0] exp_clk, exp_tick, exp_ack, exp_busy;

  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      int rdiv;
      int pos;
      bit ack;
      rdiv = int'(cfg_div[c*DIV_W +: DIV_W]);
      if (rdiv < 2) rdiv = 2;
      pos = cyc - m_start[c];
      ack = 1'b0;
      if (rst) begin
        m_act[c] = 1'b0; m_n[c] = DEF; m_pv[c] = 1'b0; m_pd[c] = DEF;
      end else if (!m_act[c]) begin
        if (cfg_req[c]) begin
          m_n[c] = rdiv; m_pv[c] = 1'b0; ack = 1'b1;
        end else if (m_pv[c]) begin
          m_n[c] = m_pd[c]; m_pv[c] = 1'b0; ack = 1'b1;
        end
        if (ch_en[c]) begin
          m_act[c] = 1'b1; m_start[c] = cyc + 1;
        end
      end else begin
        if (align || pos == m_n[c] - 1) begin
          if (m_pv[c]) begin
            m_n[c] = m_pd[c]; m_pv[c] = 1'b0; ack = 1'b1;
          end
          if (!align && !ch_en[c]) m_act[c] = 1'b0;
          else m_start[c] = cyc + 1;
        end
        if (cfg_req[c]) begin
          m_pd[c] = rdiv; m_pv[c] = 1'b1;
        end
      end
      exp_ack[c] = ack;
    end
    cyc++;
    for (int c = 0; c < NUM_CH; c++) begin
      int pos;
      pos = cyc - m_start[c];
      exp_clk[c]  = m_act[c] && (pos < (m_n[c] + 1) / 2);
      exp_tick[c] = m_act[c] && (pos == m_n[c] - 1);
      exp_busy[c] = m_pv[c];
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk_in);
    #1;
    cfg_req = '0;
    align   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_en = '0; cfg_req = '0; align = 1'b0; cfg_div = '0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ch_en = NUM_CH'($urandom); cfg_req = NUM_CH'($urandom); align = 1'(i);
      cfg_div = (NUM_CH*DIV_W)'({$urandom, $urandom});
      cycle();
      if ({clk_out, tick, cfg_ack, busy} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=0", cyc, {clk_out, tick, cfg_ack, busy});
      end
      n_cmp++;
    end
    rst = 1'b0; ch_en = '0;
    cycle();
    if ({clk_out, tick, cfg_ack, busy} !== {exp_clk, exp_tick, exp_ack, exp_busy}) begin
      n_fail++;
      $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, {clk_out, tick, cfg_ack, busy},
               {exp_clk, exp_tick, exp_ack, exp_busy});
    end
    n_cmp++;
    $display("test_reset done at cycle %0d", cyc);
  endtask

  task automatic test_default();
    do_reset();
    ch_en[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (clk_out[0] !== 1'(i % 2 == 0) || tick[0] !== 1'(i % 2 == 1)) begin
        n_fail++;
        $display("FAIL default_ratio i=%0d got clk=%b tick=%b exp clk=%b tick=%b", i, clk_out[0],
                 tick[0], 1'(i % 2 == 0), 1'(i % 2 == 1));
      end
      n_cmp++;
    end
    $display("test_default done at cycle %0d", cyc);
  endtask

  task automatic test_odd_ratio();
    do_reset();
    cfg_div[0 +: DIV_W] = 8'd5; cfg_req[0] = 1'b1;
    cycle();
    if (cfg_ack[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL odd_idle_ack got ack=%b busy=%b exp ack=1 busy=0", cfg_ack[0], busy[0]);
    end
    n_cmp++;
    ch_en[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (clk_out[0] !== 1'(i % 5 < 3) || tick[0] !== 1'(i % 5 == 4) ||
          {clk_out, tick, cfg_ack, busy} !== {exp_clk, exp_tick, exp_ack, exp_busy}) begin
        n_fail++;
        $display("FAIL odd_ratio i=%0d got=%h exp=%h", i, {clk_out, tick, cfg_ack, busy},
                 {exp_clk, exp_tick, exp_ack, exp_busy});
      end
      n_cmp++;
    end
    $display("test_odd_ratio done at cycle %0d", cyc);
  endtask

  task automatic test_mid_change();
    int acks;
    do_reset();
    cfg_div[0 +: DIV_W] = 8'd4; cfg_req[0] = 1'b1;
    cycle();
    ch_en[0] = 1'b1;
    cycle();
    cycle();
    cfg_div[0 +: DIV_W] = 8'd6; cfg_req[0] = 1'b1;
    cycle();
    if (busy[0] !== 1'b1 || clk_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_busy got busy=%b clk=%b exp busy=1 clk=0", busy[0], clk_out[0]);
    end
    n_cmp++;
    acks = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      acks += int'(cfg_ack[0]);
      if ({clk_out, tick, cfg_ack, busy} !== {exp_clk, exp_tick, exp_ack, exp_busy}) begin
        n_fail++;
        $display("FAIL mid_change i=%0d got=%h exp=%h", i, {clk_out, tick, cfg_ack, busy},
                 {exp_clk, exp_tick, exp_ack, exp_busy});
      end
      n_cmp++;
      // The new period of 6 starts two cycles after the request cycle: high, high, high.
      if (i == 1 && (cfg_ack[0] !== 1'b1 || clk_out[0] !== 1'b1)) begin
        n_fail++;
        $display("FAIL mid_ack_align got ack=%b clk=%b exp ack=1 clk=1", cfg_ack[0], clk_out[0]);
      end
      if (i == 1) n_cmp++;
    end
    if (acks != 1) begin
      n_fail++;
      $display("FAIL mid_ack_count got %0d exp 1", acks);
    end
    n_cmp++;
    $display("test_mid_change done at cycle %0d", cyc);
  endtask

  task automatic test_back_to_back();
    int acks;
    acks = 0;
    cfg_div[0 +: DIV_W] = 8'd3; cfg_req[0] = 1'b1;
    cycle();
    acks += int'(cfg_ack[0]);
    cfg_div[0 +: DIV_W] = 8'd7; cfg_req[0] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cycle();
      acks += int'(cfg_ack[0]);
      if ({clk_out, tick, cfg_ack, busy} !== {exp_clk, exp_tick, exp_ack, exp_busy}) begin
        n_fail++;
        $display("FAIL back_to_back i=%0d got=%h exp=%h", i, {clk_out, tick, cfg_ack, busy},
                 {exp_clk, exp_tick, exp_ack, exp_busy});
      end
      n_cmp++;
    end
    if (acks != 1 || m_n[0] != 7) begin
      n_fail++;
      $display("FAIL b2b_single_ack got acks=%0d ratio=%0d exp acks=1 ratio=7", acks, m_n[0]);
    end
    n_cmp++;
    $display("test_back_to_back done at cycle %0d", cyc);
  endtask

  task automatic test_clamp_stop();
    int highs;
    do_reset();
    cfg_div[0 +: DIV_W] = 8'd0; cfg_req[0] = 1'b1;
    cycle();
    ch_en[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (clk_out[0] !== 1'(i % 2 == 0)) begin
        n_fail++;
        $display("FAIL clamp_ratio i=%0d got=%b exp=%b", i, clk_out[0], 1'(i % 2 == 0));
      end
      n_cmp++;
    end
    cfg_div[0 +: DIV_W] = 8'd6; cfg_req[0] = 1'b1;
    for (int i = 0; i < 10 && cfg_ack[0] !== 1'b1; i++) cycle();
    if (cfg_ack[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_wait_ack got ack=%b exp=1 (timeout)", cfg_ack[0]);
    end
    n_cmp++;
    ch_en[0] = 1'b0;
    highs = int'(clk_out[0]);
    for (int i = 0; i < 10; i++) begin
      cycle();
      highs += int'(clk_out[0]);
      if ({clk_out, tick, cfg_ack, busy} !== {exp_clk, exp_tick, exp_ack, exp_busy}) begin
        n_fail++;
        $display("FAIL clamp_stop i=%0d got=%h exp=%h", i, {clk_out, tick, cfg_ack, busy},
                 {exp_clk, exp_tick, exp_ack, exp_busy});
      end
      n_cmp++;
    end
    if (highs != 3 || clk_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_highs got highs=%0d clk=%b exp highs=3 clk=0", highs, clk_out[0]);
    end
    n_cmp++;
    $display("test_clamp_stop done at cycle %0d", cyc);
  endtask

  task automatic test_align();
    int both;
    do_reset();
    cfg_div[0 +: DIV_W] = 8'd4; cfg_div[DIV_W +: DIV_W] = 8'd6; cfg_req[1:0] = 2'b11;
    cycle();
    ch_en[0] = 1'b1;
    cycle();
    ch_en[1] = 1'b1;
    for (int i = 0; i < int'($urandom_range(1, 10)); i++) cycle();
    align = 1'b1;
    cycle();
    if (clk_out[1:0] !== 2'b11) begin
      n_fail++;
      $display("FAIL align_rise got=%b exp=11", clk_out[1:0]);
    end
    n_cmp++;
    both = 0;
    for (int i = 0; i < 24; i++) begin
      both += int'(tick[0] & tick[1]);
      if ({clk_out, tick, cfg_ack, busy} !== {exp_clk, exp_tick, exp_ack, exp_busy}) begin
        n_fail++;
        $display("FAIL align i=%0d got=%h exp=%h", i, {clk_out, tick, cfg_ack, busy},
                 {exp_clk, exp_tick, exp_ack, exp_busy});
      end
      n_cmp++;
      cycle();
    end
    if (both != 2) begin
      n_fail++;
      $display("FAIL align_coincident_ticks got %0d exp 2", both);
    end
    n_cmp++;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    if ({clk_out, tick, cfg_ack, busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_period_reset got=%h exp=0", {clk_out, tick, cfg_ack, busy});
    end
    n_cmp++;
    rst = 1'b0;
    $display("test_align done at cycle %0d", cyc);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 15) == 0) ch_en[c] = ~ch_en[c];
        if ($urandom_range(0, 19) == 0) begin
          cfg_req[c] = 1'b1;
          cfg_div[c*DIV_W +: DIV_W] = ($urandom_range(0, 30) == 0) ? 8'd255 : 8'($urandom_range(0, 9));
        end
      end
      align = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      cycle();
      if ({clk_out, tick, cfg_ack, busy} !== {exp_clk, exp_tick, exp_ack, exp_busy}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, {clk_out, tick, cfg_ack, busy},
                 {exp_clk, exp_tick, exp_ack, exp_busy});
      end
      n_cmp++;
    end
    rst = 1'b0;
    $display("test_random done at cycle %0d", cyc);
  endtask

  initial begin
    rst = 1'b1; ch_en = '0; cfg_req = '0; align = 1'b0; cfg_div = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_act[c] = 1'b0; m_start[c] = 0; m_n[c] = DEF; m_pv[c] = 1'b0; m_pd[c] = DEF;
    end
    test_reset();
    test_default();
    test_odd_ratio();
    test_mid_change();
    test_back_to_back();
    test_clamp_stop();
    test_align();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d exp completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
